ms_timer: RTL and testbench

MS_TIMER -- requirements
Module: ms_timer

---
 rtl/ms_timer.sv | 99 +++++++++
 tb/tb_ms_timer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ms_timer.sv
// Millisecond countdown timer: a prescaler divides clk down to 1 ms ticks that
// decrement remaining_ms. Define MS_TIMER_AUTO_RELOAD_EN to make it periodic.
module ms_timer #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] load_ms,
    output logic        busy,
    output logic [15:0] remaining_ms,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(CLK_PER_MS - 1);

    state_t      r_state;
    logic [15:0] r_presc;
    logic [15:0] r_remaining;
    logic        r_busy;
    logic        r_done;
    logic        w_tick;
`ifdef MS_TIMER_AUTO_RELOAD_EN
    logic [15:0] r_reload;
`endif

    assign w_tick       = (r_presc == PRESC_MAX);
    assign busy         = r_busy;
    assign remaining_ms = r_remaining;
    assign done         = r_done;

    // NOTE: every register below is assigned with <= so all of them see the
    // pre-edge values of each other; blocking here would create ordering bugs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MS_TIMER_AUTO_RELOAD_EN
            r_reload    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
`ifdef MS_TIMER_AUTO_RELOAD_EN
                        r_reload <= load_ms;
`endif
                        r_remaining <= load_ms;
                        r_presc     <= '0;
                        if (load_ms == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // stop beats start, and both beat a coincident tick
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_presc <= '0;
                    end else if (start) begin
`ifdef MS_TIMER_AUTO_RELOAD_EN
                        r_reload <= load_ms;
`endif
                        r_remaining <= load_ms;
                        r_presc     <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (r_remaining > 16'd1) begin
                            r_remaining <= r_remaining - 16'd1;
                        end else if (r_remaining == 16'd1) begin
                            r_done <= 1'b1;
`ifdef MS_TIMER_AUTO_RELOAD_EN
                            r_remaining <= r_reload;
`else
                            r_remaining <= '0;
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
`endif
                        end
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_timer.sv
// Self-checking bench for ms_timer: deadline-based reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_ms_timer;

    localparam int C = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] load_ms = '0;
    logic        busy;
    logic [15:0] remaining_ms;
    logic        done;

    ms_timer #(.CLK_PER_MS(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load_ms(load_ms),
        .busy(busy), .remaining_ms(remaining_ms), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int edge_cnt = 0;

    // Model: a running countdown is described by its start edge and length;
    // remaining time and expiry follow from elapsed edges by arithmetic.
    bit m_run  = 0;
    bit m_done = 0;
    int m_t0 = 0, m_n = 0, m_hold = 0, m_reload = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    endtask

    function automatic int exp_rem();
        return m_run ? m_n - (edge_cnt - m_t0) / C : m_hold;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_hold = 0; m_reload = 0;
    endtask

    task automatic model_edge(input bit s, input bit p, input int ld);
        int rem_before;
        rem_before = m_run ? m_n - (edge_cnt - 1 - m_t0) / C : m_hold;
        m_done = 0;
        if (m_run) begin
            if (p) begin
                m_run = 0; m_hold = rem_before;
            end else if (s) begin
                m_t0 = edge_cnt; m_n = ld; m_reload = ld;
            end else if (edge_cnt - m_t0 == m_n * C) begin
                m_done = 1;
`ifdef MS_TIMER_AUTO_RELOAD_EN
                m_t0 = edge_cnt; m_n = m_reload;
`else
                m_run = 0; m_hold = 0;
`endif
            end
        end else if (s && !p) begin
            m_reload = ld; m_hold = ld;
            if (ld == 0) m_done = 1;
            else begin m_run = 1; m_t0 = edge_cnt; m_n = ld; end
        end
    endtask

    // Called at a negedge: drive inputs, take one edge, compare at the next negedge.
    task automatic step(input bit s, input bit p, input int ld);
        start = s; stop = p; load_ms = 16'(ld);
        @(posedge clk);
        edge_cnt++;
        model_edge(s, p, ld);
        @(negedge clk);
        check("busy", int'(busy), int'(m_run));
        check("remaining_ms", int'(remaining_ms), exp_rem());
        check("done", int'(done), int'(m_done));
        if (done) n_done++;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0);
    endtask

    task automatic check_outs(input string tag, input int b, input int r, input int d);
        check({tag, ".busy"}, int'(busy), b);
        check({tag, ".rem"}, int'(remaining_ms), r);
        check({tag, ".done"}, int'(done), d);
    endtask

    int base;

    initial begin
        #12;
        check_outs("reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // load 3: 3,2,1 each 10 cycles, done on cycle 30
        step(1, 0, 3);   check_outs("l3_start", 1, 3, 0);
        run(9);          check_outs("l3_c9", 1, 3, 0);
        run(1);          check_outs("l3_c10", 1, 2, 0);
        run(19);         check_outs("l3_c29", 1, 1, 0);
        run(1);
`ifdef MS_TIMER_AUTO_RELOAD_EN
        check_outs("l3_c30", 1, 3, 1);
        run(1);          check_outs("l3_c31", 1, 3, 0);
        step(0, 1, 0);   check_outs("l3_stop", 0, 3, 0);
`else
        check_outs("l3_c30", 0, 0, 1);
        run(1);          check_outs("l3_c31", 0, 0, 0);
`endif

        // load 0: immediate single done, never busy
        step(1, 0, 0);   check_outs("l0", 0, 0, 1);
        run(2);          check_outs("l0_after", 0, 0, 0);

        // load 5, stop on cycle 23
        base = n_done;
        step(1, 0, 5);
        run(22);         check_outs("l5_c22", 1, 3, 0);
        step(0, 1, 0);   check_outs("l5_stop", 0, 3, 0);
        run(60);         check_outs("l5_held", 0, 3, 0);
        check("l5_no_done", n_done - base, 0);
        step(0, 1, 0);   check_outs("stop_idle", 0, 3, 0);

        // load 4, restart with 2 on cycle 15: done on cycle 35 only
        base = n_done;
        step(1, 0, 4);
        run(14);
        step(1, 0, 2);   check_outs("rs_c15", 1, 2, 0);
        run(19);
        check("rs_no_early_done", n_done - base, 0);
        run(1);
`ifdef MS_TIMER_AUTO_RELOAD_EN
        check_outs("rs_c35", 1, 2, 1);
        step(0, 1, 0);
`else
        check_outs("rs_c35", 0, 0, 1);
`endif
        run(10);
        check("rs_one_done", n_done - base, 1);

        // start+stop together on cycle 20: stop wins, tick discarded
        base = n_done;
        step(1, 0, 3);
        run(19);
        step(1, 1, 4);   check_outs("ss_c20", 0, 2, 0);
        run(40);
        check("ss_no_done", n_done - base, 0);

        // reset on cycle 12 of a load 2 run
        base = n_done;
        step(1, 0, 2);
        run(11);         check_outs("rst_c11", 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_outs("rst_async", 0, 0, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(40);         check_outs("rst_after", 0, 0, 0);
        check("rst_no_done", n_done - base, 0);

`ifdef MS_TIMER_AUTO_RELOAD_EN
        // periodic: done on cycles 20, 40, 60, busy throughout, stop ends it
        step(1, 0, 2);
        for (int k = 0; k < 3; k++) begin
            run(19);     check_outs("ar_pre", 1, 1, 0);
            run(1);      check_outs("ar_tick", 1, 2, 1);
        end
        step(0, 1, 0);   check_outs("ar_stop", 0, 2, 0);
`endif

        // random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            bit s, p;
            int ld;
            s  = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 39) == 0);
            ld = m_run ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 4));
            step(s, p, ld);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
